// File: rtl/dsp48_pkg.sv
// Shared definitions for the DSP48A1-style slice: operand select codes,
// opmode field layout, default widths and carry-in source names.
package dsp48_pkg;

    localparam int P_W  = 48;
    localparam int M_W  = 36;
    localparam int AB_W = 18;
    localparam int DU_W = 12;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    localparam CINSEL_OPMODE5 = "OPMODE5";
    localparam CINSEL_CARRYIN = "CARRYIN";

    typedef struct packed {
        logic       sub;
        logic       rsvd6;
        logic       cin_op;
        logic       rsvd4;
        logic [1:0] zsel;
        logic [1:0] xsel;
    } opmode_t;

endpackage

// File: rtl/dsp_post_adder_acc_pipe_reg.sv
// Optional pipeline stage: a CE-gated register with async active-low
// clear, or a plain wire when EN_REG is 0.
module pipe_reg #(
    parameter int WIDTH  = 1,
    parameter bit EN_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (EN_REG) begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;

            always_comb begin
                data_d = data_q;
                if (ce) data_d = d;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) data_q <= '0;
                else      data_q <= data_d;
            end

            assign q = data_q;
        end else begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp_post_adder_acc.sv
// Post-adder / accumulator stage: X/Z operand select, add or subtract
// with carry-in, optional P and carry-out registers, cascade output.
module dsp_post_adder_acc
    import dsp48_pkg::*;
#(
    parameter bit PREG        = 1'b1,
    parameter bit CARRYOUTREG = 1'b1,
    parameter bit OPMODEREG   = 1'b1,
    parameter bit CARRYINREG  = 1'b1,
    parameter     CARRYINSEL  = "OPMODE5",
    parameter int P_WIDTH     = 48,
    parameter int M_WIDTH     = 36
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CEP,
    input  logic               CECARRYIN,
    input  logic               CEOPMODE,
    input  logic [7:0]         opmode,
    input  logic [M_WIDTH-1:0] M,
    input  logic [P_WIDTH-1:0] C,
    input  logic [17:0]        D,
    input  logic [17:0]        A,
    input  logic [17:0]        B,
    input  logic [P_WIDTH-1:0] PCIN,
    input  logic               CARRYIN,
    output logic [P_WIDTH-1:0] P,
    output logic [P_WIDTH-1:0] PCOUT,
    output logic               CARRYOUT,
    output logic               CARRYOUTF
);

    logic [7:0]         op_raw;
    opmode_t            op_i;
    logic               cin_sel;
    logic               cin_i;
    logic [P_WIDTH-1:0] p_r;
    logic [P_WIDTH-1:0] p_fb;
    logic               co_r;
    logic [P_WIDTH-1:0] x_op;
    logic [P_WIDTH-1:0] z_op;
    logic [P_WIDTH:0]   sum;
    logic               unused_ok;

    assign unused_ok = ^{D[17:DU_W], op_i.rsvd6, op_i.rsvd4};

    pipe_reg #(.WIDTH(8), .EN_REG(OPMODEREG)) u_opmode_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CEOPMODE),
        .d   (opmode),
        .q   (op_raw)
    );

    assign op_i = opmode_t'(op_raw);

    always_comb begin
        cin_sel = op_i.cin_op;
        if (CARRYINSEL == CINSEL_CARRYIN) cin_sel = CARRYIN;
    end

    pipe_reg #(.WIDTH(1), .EN_REG(CARRYINREG)) u_cin_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CECARRYIN),
        .d   (cin_sel),
        .q   (cin_i)
    );

    // Without a P register there is nothing to feed back; tie it off
    // so an illegal opmode cannot create a combinational loop.
    generate
        if (PREG) begin : g_fb
            assign p_fb = p_r;
        end else begin : g_nofb
            assign p_fb = '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    assert (op_i.xsel != X_P && op_i.zsel != Z_P);
                end
            end
        end
    endgenerate

    always_comb begin
        x_op = '0;
        case (op_i.xsel)
            X_ZERO:  x_op = '0;
            X_M:     x_op = {{(P_WIDTH-M_WIDTH){M[M_WIDTH-1]}}, M};
            X_P:     x_op = p_fb;
            X_DAB:   x_op = P_WIDTH'({D[DU_W-1:0], A, B});
            default: x_op = '0;
        endcase
    end

    always_comb begin
        z_op = '0;
        case (op_i.zsel)
            Z_ZERO:  z_op = '0;
            Z_PCIN:  z_op = PCIN;
            Z_P:     z_op = p_fb;
            Z_C:     z_op = C;
            default: z_op = '0;
        endcase
    end

    // Bit P_WIDTH is the carry when adding and the borrow when subtracting.
    always_comb begin
        sum = '0;
        if (op_i.sub) begin
            sum = {1'b0, z_op} - ({1'b0, x_op} + {{P_WIDTH{1'b0}}, cin_i});
        end else begin
            sum = {1'b0, z_op} + {1'b0, x_op} + {{P_WIDTH{1'b0}}, cin_i};
        end
    end

    pipe_reg #(.WIDTH(P_WIDTH), .EN_REG(PREG)) u_p_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CEP),
        .d   (sum[P_WIDTH-1:0]),
        .q   (p_r)
    );

    pipe_reg #(.WIDTH(1), .EN_REG(CARRYOUTREG)) u_co_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CEP),
        .d   (sum[P_WIDTH]),
        .q   (co_r)
    );

    assign P         = p_r;
    assign PCOUT     = p_r;
    assign CARRYOUT  = co_r;
    assign CARRYOUTF = co_r;

endmodule
